// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: opcodes, FSM encoding,
// flag bit positions and the latched-command record.
package alu_pkg;

  localparam int DW   = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  // ALU opcodes; any other value is undefined and produces a zero result.
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1101;

  // Execute-stage FSM encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  // Bit positions inside res_flags.
  localparam int FLAG_ZF = 3;
  localparam int FLAG_CF = 2;
  localparam int FLAG_OF = 1;
  localparam int FLAG_SF = 0;

  // Everything captured from a command at acceptance time.
  typedef struct packed {
    logic [3:0]    op;
    logic [AW-1:0] rd;
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
  } cmd_latch_t;

  // Packs the individual ALU flags into the res_flags layout.
  function automatic logic [3:0] pack_flags(input logic zf, input logic cf,
                                            input logic of, input logic sf);
    logic [3:0] f;
    f          = '0;
    f[FLAG_ZF] = zf;
    f[FLAG_CF] = cf;
    f[FLAG_OF] = of;
    f[FLAG_SF] = sf;
    return f;
  endfunction

endpackage

// File: rtl/alu_exec_stage_regfile32.sv
// 32-entry register file: two operand read ports, one debug read port and a
// single synchronous write port. Register 0 is hardwired to zero.
module regfile32
  import alu_pkg::*;
#(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [4:0]    raddr_b,
  output logic [DW-1:0] rdata_b,
  input  logic [4:0]    dbg_addr,
  output logic [DW-1:0] dbg_data,
  input  logic          we,
  input  logic [4:0]    waddr,
  input  logic [DW-1:0] wdata
);

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];

  // Next-state of the array: a single write, never to register 0.
  always_comb begin
    // NOTE: every always_comb output gets a full default first so no path
    // leaves it unassigned, which is what would otherwise infer a latch.
    regs_d = regs_q;
    if (we && (waddr != 5'd0)) begin
      regs_d[waddr] = wdata;
    end
  end

  // Register array update with synchronous clear.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only; blocking
    // assignments belong in always_comb.
    if (rst) begin
      // NOTE: the whole array is cleared on reset because software relies on
      // every register reading zero afterwards, so this storage is built from
      // resettable flops rather than a RAM.
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata_a  = (raddr_a  == 5'd0) ? '0 : regs_q[raddr_a];
  assign rdata_b  = (raddr_b  == 5'd0) ? '0 : regs_q[raddr_b];
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs_q[dbg_addr];

endmodule

// File: rtl/alu_exec_stage.sv
// Operand-fetch / execute / write-back stage in front of the combinational
// ALU. One command in flight at a time: IDLE -> EXEC -> WB -> HOLD -> IDLE.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [4:0]    cmd_rs1,
  input  logic [4:0]    cmd_rs2,
  input  logic [4:0]    cmd_rd,
  input  logic          cmd_use_imm,
  input  logic [DW-1:0] cmd_imm,
  output logic [3:0]    ALU_OP,
  output logic [DW-1:0] ALU_A,
  output logic [DW-1:0] ALU_B,
  input  logic [DW-1:0] ALU_F,
  input  logic          ZF,
  input  logic          CF,
  input  logic          OF,
  input  logic          SF,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic [3:0]    res_flags,
  input  logic          ld_we,
  input  logic [4:0]    ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic [4:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
);

  logic [1:0]    state_q,     state_d;
  cmd_latch_t    lat_q,       lat_d;
  logic [DW-1:0] res_data_q,  res_data_d;
  logic [3:0]    res_flags_q, res_flags_d;
  logic          res_valid_q, res_valid_d;

  logic [DW-1:0] rf_rdata_a;
  logic [DW-1:0] rf_rdata_b;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;

  regfile32 #(
    .NREG (NREG),
    .DW   (DW)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .raddr_a  (cmd_rs1),
    .rdata_a  (rf_rdata_a),
    .raddr_b  (cmd_rs2),
    .rdata_b  (rf_rdata_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata)
  );

  // External loads have priority over commands, and only IDLE listens.
  assign cmd_ready = (state_q == ST_IDLE) && !ld_we;

  // FSM next state, operand latching, result capture and the shared
  // write-port mux (loads in IDLE, write-back in WB; never both).
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    res_valid_d = res_valid_q;
    rf_we       = 1'b0;
    rf_waddr    = ld_addr;
    rf_wdata    = ld_data;

    case (state_q)
      ST_IDLE: begin
        if (ld_we) begin
          rf_we = 1'b1;
        end else if (cmd_valid) begin
          lat_d.op  = cmd_op;
          lat_d.rd  = cmd_rd;
          lat_d.opa = rf_rdata_a;
          lat_d.opb = cmd_use_imm ? cmd_imm : rf_rdata_b;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_data_d  = ALU_F;
        res_flags_d = pack_flags(ZF, CF, OF, SF);
        state_d     = ST_WB;
      end
      ST_WB: begin
        rf_we       = (lat_q.rd != 5'd0);
        rf_waddr    = lat_q.rd;
        rf_wdata    = res_data_q;
        res_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage state; reset drops any command in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lat_q       <= '0;
      res_data_q  <= '0;
      res_flags_q <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
      res_valid_q <= res_valid_d;
    end
  end

  // The latched command drives the ALU; it only changes on acceptance, so
  // the ALU inputs hold their last values outside EXEC.
  assign ALU_OP    = lat_q.op;
  assign ALU_A     = lat_q.opa;
  assign ALU_B     = lat_q.opb;

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_flags = res_flags_q;

endmodule
